pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural PC register of the pipelined MIPS core and sequences instruction fetch.
- Issues fetch requests to instruction memory through a req/ready handshake.
- Applies hazard-unit stalls, and applies redirects (exception, eret, branch, jump) in a fixed priority order.
- Buffers one redirect that arrives while a fetch is in flight, so no redirect is lost and no wrong-path instruction reaches IF/ID.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- if_stall  input  1  hazard unit freezes the IF stage
- exc_req  input  1  exception redirect pulse
- eret_req  input  1  eret redirect pulse
- epc  input  32  eret target address
- br_taken  input  1  branch-taken redirect pulse
- br_target  input  32  branch target address
- jump  input  1  j/jal/jr redirect pulse
- j_target  input  32  jump target address
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address
- imem_ready  input  1  fetch data valid this cycle
- pc  output  32  current PC
- if_valid  output  1  fetched instruction is valid for IF/ID
- if_pc  output  32  PC of the instruction flagged by if_valid
- misalign  output  1  one-cycle pulse: an applied target had bits [1:0] != 0

Behaviour:
- Reset (synchronous, active-high), taking effect on the clock edge:
  - pc = RESET_PC, state = FETCH, pending buffer empty.
  - if_valid = 0, misalign = 0, if_pc = RESET_PC.
  - Reset mid-fetch discards the outstanding fetch. A late imem_ready is ignored because the memory handshake is also reset.
- States:
  - FETCH: imem_req = 1, imem_addr = pc. imem_addr stays stable until imem_ready.
  - HOLD: imem_req = 0. A completed instruction is held for a stalled IF/ID.
- Redirect target priority: exc_req > eret_req > br_taken > jump. Targets are EXC_VECTOR, epc, br_target and j_target respectively.
  - Applied target has bits [1:0] forced to 0.
  - misalign pulses in the cycle the target is applied.
- FETCH, imem_ready = 0:
  - A redirect this cycle is written to the pending buffer.
  - A new redirect overwrites the buffer only if its priority is equal to or higher than the stored one.
  - pc is unchanged.
- FETCH, imem_ready = 1, redirect this cycle or pending:
  - The instruction is discarded (if_valid = 0).
  - pc <= winning target (the higher of the pending and current redirects). Pending buffer is cleared. Stay in FETCH.
  - Redirect overrides if_stall.
- FETCH, imem_ready = 1, no redirect, if_stall = 0:
  - if_valid = 1 and if_pc = pc in the same cycle.
  - pc <= pc + 4 (32-bit wrap). Stay in FETCH.
- FETCH, imem_ready = 1, no redirect, if_stall = 1:
  - Go to HOLD. if_valid = 1 and if_pc = pc are held.
  - pc is unchanged.
- HOLD:
  - if_valid stays 1 while if_stall = 1.
  - When if_stall falls with no redirect: pc <= pc + 4, go to FETCH.
  - On a redirect in any HOLD cycle: if_valid <= 0 next cycle, pc <= target, go to FETCH.
- Simultaneous exc_req and br_taken: the exception wins and the branch is dropped.
- Back-to-back fetches with imem_ready tied high give one instruction per cycle.
- No combinational path from the redirect inputs to imem_addr. Redirects become visible on imem_addr one cycle later.

Decomposition:
- Shared package cpu_defs holds:
  - RESET_PC and EXC_VECTOR constants.
  - Redirect-source encoding: NONE=0, JUMP=1, BR=2, ERET=3, EXC=4. A numerically higher code means higher priority.
  - FETCH/HOLD state encoding.
- One sub-module is natural: redirect_arb, a combinational priority select of source code and target, also used to compare against the pending buffer.
- The PC register, FSM and pending buffer stay in pc_sequencer.

Test Plan:
- Reset, then imem_ready tied to 1:
  - imem_addr reads 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - if_valid = 1 each cycle, with if_pc matching imem_addr.
- Fetch at 0x3004 with imem_ready held 0 for 3 cycles, br_taken with br_target = 0x3100 in cycle 1:
  - On ready, if_valid = 0.
  - The next imem_addr is 0x3100.
- if_stall = 1 for 2 cycles after the fetch of 0x3008 completes:
  - imem_req = 0 and if_valid = 1 with if_pc = 0x3008 are held.
  - After the stall drops, imem_addr = 0x300C.
- exc_req and jump (j_target = 0x3200) in the same cycle during HOLD:
  - Next imem_addr = 0x4180.
  - if_valid = 0.
- Pending jump to 0x3040, then eret with epc = 0x3300 before ready:
  - The eret replaces the pending jump; next imem_addr = 0x3300.
  - A further br_taken before ready does not replace the pending eret.
- jump with j_target = 0x3006 → imem_addr = 0x3004, misalign pulses for 1 cycle. Reset asserted mid-fetch → imem_addr = 0x3000 the following cycle.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions: reset/exception addresses, redirect source codes and
// the fetch sequencer state encoding.
package cpu_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // A numerically higher code wins arbitration.
  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_JUMP = 3'd1,
    SRC_BR   = 3'd2,
    SRC_ERET = 3'd3,
    SRC_EXC  = 3'd4
  } redir_src_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } seq_state_e;

  typedef struct packed {
    redir_src_e  src;
    logic [31:0] target;
  } redir_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the PC sequencer and instruction memory.
// Handshake: imem_req is held high with imem_addr stable until the cycle
// imem_ready is high; that cycle completes the fetch of imem_addr. imem_ready
// outside an outstanding request carries no meaning.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer_redirect_arb.sv
// Fixed-priority redirect select (exc > eret > branch > jump), then a merge of the
// current winner with the buffered redirect; ties go to the newer request.
module redirect_arb #(
  parameter logic [31:0] EXC_VECTOR = cpu_defs::EXC_VECTOR
) (
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [31:0]     epc,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  input  logic            jump,
  input  logic [31:0]     j_target,
  input  cpu_defs::redir_t pend,
  output cpu_defs::redir_t cur,
  output cpu_defs::redir_t win
);
  import cpu_defs::*;

  always_comb begin
    cur = '{src: SRC_NONE, target: 32'h0};
    if (exc_req)       cur = '{src: SRC_EXC,  target: EXC_VECTOR};
    else if (eret_req) cur = '{src: SRC_ERET, target: epc};
    else if (br_taken) cur = '{src: SRC_BR,   target: br_target};
    else if (jump)     cur = '{src: SRC_JUMP, target: j_target};

    win = (cur.src >= pend.src) ? cur : pend;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and fetch sequencer: issues fetches, freezes on
// hazard stalls and applies prioritised redirects, buffering one during a fetch.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_defs::EXC_VECTOR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_stall,
  input  logic                 exc_req,
  input  logic                 eret_req,
  input  logic [31:0]          epc,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  input  logic                 jump,
  input  logic [31:0]          j_target,
  pc_sequencer_if.master       imem,
  output logic [31:0]          pc,
  output logic                 if_valid,
  output logic [31:0]          if_pc,
  output logic                 misalign,
  output cpu_defs::seq_state_e dbg_state
);
  import cpu_defs::*;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  redir_t      pend_q, pend_d;
  logic        misalign_q, misalign_d;
  redir_t      cur_redir, win_redir;
  logic        imem_req_c;
  logic        if_valid_c;

  redirect_arb #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jump      (jump),
    .j_target  (j_target),
    .pend      (pend_q),
    .cur       (cur_redir),
    .win       (win_redir)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    misalign_d = 1'b0;
    imem_req_c = 1'b0;
    if_valid_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (!imem.imem_ready) begin
          // imem_addr must stay stable, so redirects wait in the buffer.
          if (cur_redir.src != SRC_NONE && cur_redir.src >= pend_q.src)
            pend_d = cur_redir;
        end else if (win_redir.src != SRC_NONE) begin
          pc_d       = align_pc(win_redir.target);
          misalign_d = |win_redir.target[1:0];
          pend_d     = '{src: SRC_NONE, target: 32'h0};
        end else begin
          if_valid_c = 1'b1;
          if (if_stall) state_d = ST_HOLD;
          else          pc_d    = pc_q + 32'd4;
        end
      end
      ST_HOLD: begin
        if_valid_c = 1'b1;
        if (win_redir.src != SRC_NONE) begin
          pc_d       = align_pc(win_redir.target);
          misalign_d = |win_redir.target[1:0];
          pend_d     = '{src: SRC_NONE, target: 32'h0};
          state_d    = ST_FETCH;
        end else if (!if_stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= '{src: SRC_NONE, target: 32'h0};
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.imem_req  = imem_req_c;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign if_valid       = if_valid_c;
  assign if_pc          = pc_q;
  assign misalign       = misalign_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch streaming, buffered redirects, stalls,
// priority, misaligned targets, wrap and mid-fetch reset.
module tb_pc_sequencer;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_stall;
  logic        exc_req, eret_req, br_taken, jump;
  logic [31:0] epc, br_target, j_target;
  logic [31:0] pc, if_pc;
  logic        if_valid, misalign;
  seq_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if imem_bus();

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .if_stall  (if_stall),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jump      (jump),
    .j_target  (j_target),
    .imem      (imem_bus),
    .pc        (pc),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .misalign  (misalign),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_redirects();
    exc_req  = 1'b0;
    eret_req = 1'b0;
    br_taken = 1'b0;
    jump     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; if_stall = 1'b0; clear_redirects();
    epc = 32'h0; br_target = 32'h0; j_target = 32'h0;
    imem_bus.imem_ready = 1'b0;

    // reset state
    do_reset();
    #1;
    check("rst_addr",     imem_bus.imem_addr, 32'h3000);
    check("rst_pc",       pc, 32'h3000);
    check("rst_if_pc",    if_pc, 32'h3000);
    check("rst_valid",    {31'b0, if_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_req",      {31'b0, imem_bus.imem_req}, 32'd1);
    check("rst_state",    32'(dbg_state), 32'(ST_FETCH));

    // streaming with ready tied high
    imem_bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stream_addr",  imem_bus.imem_addr, 32'h3000 + 32'(4 * i));
      check("stream_valid", {31'b0, if_valid}, 32'd1);
      check("stream_if_pc", if_pc, 32'h3000 + 32'(4 * i));
      step();
    end

    // branch arriving while fetch of 0x3004 waits three cycles
    do_reset();
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready = 1'b0;
    br_taken = 1'b1; br_target = 32'h3100;
    #1;
    check("br_wait_valid", {31'b0, if_valid}, 32'd0);
    check("br_wait_addr",  imem_bus.imem_addr, 32'h3004);
    step();
    br_taken = 1'b0;
    #1;
    check("br_addr_stable", imem_bus.imem_addr, 32'h3004);
    step();
    step();
    imem_bus.imem_ready = 1'b1;
    #1;
    check("br_ready_discard", {31'b0, if_valid}, 32'd0);
    step();
    #1;
    check("br_new_addr", imem_bus.imem_addr, 32'h3100);
    check("br_new_valid", {31'b0, if_valid}, 32'd1);
    check("br_no_misalign", {31'b0, misalign}, 32'd0);

    // stall after fetch of 0x3008 completes
    do_reset();
    imem_bus.imem_ready = 1'b1;
    step();
    step();
    if_stall = 1'b1;
    #1;
    check("stall_first_valid", {31'b0, if_valid}, 32'd1);
    check("stall_first_if_pc", if_pc, 32'h3008);
    step();
    imem_bus.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("hold_req",   {31'b0, imem_bus.imem_req}, 32'd0);
      check("hold_valid", {31'b0, if_valid}, 32'd1);
      check("hold_if_pc", if_pc, 32'h3008);
      check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
      step();
    end
    if_stall = 1'b0;
    step();
    #1;
    check("unstall_addr", imem_bus.imem_addr, 32'h300C);
    check("unstall_req",  {31'b0, imem_bus.imem_req}, 32'd1);

    // exception and jump together during HOLD
    imem_bus.imem_ready = 1'b1;
    if_stall = 1'b1;
    step();
    exc_req = 1'b1; jump = 1'b1; j_target = 32'h3200;
    step();
    clear_redirects();
    if_stall = 1'b0;
    imem_bus.imem_ready = 1'b0;
    #1;
    check("exc_addr",  imem_bus.imem_addr, 32'h4180);
    check("exc_valid", {31'b0, if_valid}, 32'd0);
    check("exc_state", 32'(dbg_state), 32'(ST_FETCH));

    // pending jump replaced by eret, eret not replaced by later branch
    jump = 1'b1; j_target = 32'h3040;
    step();
    jump = 1'b0; eret_req = 1'b1; epc = 32'h3300;
    step();
    eret_req = 1'b0; br_taken = 1'b1; br_target = 32'h3500;
    #1;
    check("pend_addr_stable", imem_bus.imem_addr, 32'h4180);
    step();
    br_taken = 1'b0;
    imem_bus.imem_ready = 1'b1;
    #1;
    check("pend_discard", {31'b0, if_valid}, 32'd0);
    step();
    #1;
    check("pend_eret_addr", imem_bus.imem_addr, 32'h3300);

    // misaligned jump target
    jump = 1'b1; j_target = 32'h3006;
    #1;
    check("mis_discard", {31'b0, if_valid}, 32'd0);
    step();
    jump = 1'b0;
    imem_bus.imem_ready = 1'b0;
    #1;
    check("mis_addr",  imem_bus.imem_addr, 32'h3004);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    step();
    #1;
    check("mis_pulse_end", {31'b0, misalign}, 32'd0);

    // 32-bit wrap of the sequential PC
    imem_bus.imem_ready = 1'b1;
    jump = 1'b1; j_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    #1;
    check("wrap_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    step();
    #1;
    check("wrap_zero", imem_bus.imem_addr, 32'h0000_0000);

    // reset while a fetch is outstanding
    imem_bus.imem_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_addr",  imem_bus.imem_addr, 32'h3000);
    check("midrst_valid", {31'b0, if_valid}, 32'd0);
    imem_bus.imem_ready = 1'b1;
    #1;
    check("midrst_fetch_valid", {31'b0, if_valid}, 32'd1);
    check("midrst_fetch_pc",    if_pc, 32'h3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
